// File: rtl/dcache_wb_direct_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM states,
// default geometry and byte-address field slice macros.
`ifndef DCACHE_WB_DIRECT_PKG_SV
`define DCACHE_WB_DIRECT_PKG_SV

// Address layout: {tag, set, word, 2'b byte offset}; L/S are the line/set index widths.
`define DC_WORD_F(a, L)    a[(L)+1:2]
`define DC_SET_F(a, L, S)  a[(L)+(S)+1:(L)+2]
`define DC_TAG_F(a, L, S)  a[31:(L)+(S)+2]

package dcache_wb_direct_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_SET_ADDR_LEN  = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWAP_OUT = 2'd1,
    SWAP_IN  = 2'd2,
    INSTALL  = 2'd3
  } cacheState_t;

endpackage

`endif

// File: rtl/dcache_wb_direct_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: combinational
// read of one set, per-byte store into one word, whole-line install.
module dcache_line_array
  import dcache_wb_direct_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SET_ADDR_LEN-1:0]             setIdx,
  input  logic [LINE_ADDR_LEN-1:0]            wordIdx,
  output logic [TAG_ADDR_LEN-1:0]             tagOut,
  output logic                                validOut,
  output logic                                dirtyOut,
  output logic [31:0]                         wordOut,
  input  logic [3:0]                          byteWe,
  input  logic [31:0]                         wrData,
  input  logic                                installEn,
  input  logic [TAG_ADDR_LEN-1:0]             installTag,
  input  logic [(2**LINE_ADDR_LEN)-1:0][31:0] installLine
);

  localparam int LINE_WORDS = 2**LINE_ADDR_LEN;
  localparam int SETS       = 2**SET_ADDR_LEN;

  logic [LINE_WORDS-1:0][31:0] dataMem [SETS];
  logic [TAG_ADDR_LEN-1:0]     tagMem  [SETS];
  logic [SETS-1:0]             validBits;
  logic [SETS-1:0]             dirtyBits;

  assign tagOut   = tagMem[setIdx];
  assign validOut = validBits[setIdx];
  assign dirtyOut = dirtyBits[setIdx];
  assign wordOut  = dataMem[setIdx][wordIdx];

  // NOTE: tag/data storage has no reset; a line is meaningless until its valid bit is set,
  // and leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (installEn) begin
      dataMem[setIdx] <= installLine;
      tagMem[setIdx]  <= installTag;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (byteWe[b]) dataMem[setIdx][wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (installEn) begin
      validBits[setIdx] <= 1'b1;
      dirtyBits[setIdx] <= 1'b0;
    end else if (|byteWe) begin
      dirtyBits[setIdx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back, write-allocate data cache with word-serial line swap.
// Optional DCACHE_STATS_EN adds saturating hit/miss/write-back counters.
module dcache_wb_direct
  import dcache_wb_direct_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [3:0]  wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
`endif
);

  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_WORDS   = 2**LINE_ADDR_LEN;

  cacheState_t                 state, nextState;
  logic [LINE_ADDR_LEN-1:0]    cnt;
  logic [TAG_ADDR_LEN-1:0]     reqTag;
  logic [SET_ADDR_LEN-1:0]     reqSet;
  logic [LINE_WORDS-1:0][31:0] fillBuf;

  logic [TAG_ADDR_LEN-1:0]  addrTag, lookupTag, lineTag;
  logic [SET_ADDR_LEN-1:0]  addrSet, lookupSet;
  logic [LINE_ADDR_LEN-1:0] lookupWord;
  logic [31:0]              lineWord;
  logic [3:0]               storeWe;
  logic request, hit, idleHit, missEntry, lastWord, lineValid, lineDirty;
  logic unusedByteOffset;

  assign addrTag          = `DC_TAG_F(addr, LINE_ADDR_LEN, SET_ADDR_LEN);
  assign addrSet          = `DC_SET_F(addr, LINE_ADDR_LEN, SET_ADDR_LEN);
  assign unusedByteOffset = ^addr[1:0];

  // Outside IDLE the set/tag come from the miss-entry capture; during write-back the
  // word index walks the victim line.
  assign lookupSet  = (state == IDLE) ? addrSet : reqSet;
  assign lookupTag  = (state == IDLE) ? addrTag : reqTag;
  assign lookupWord = (state == SWAP_OUT) ? cnt : `DC_WORD_F(addr, LINE_ADDR_LEN);

  assign request   = rd_req | (|wr_req);
  assign hit       = lineValid && (lineTag == lookupTag);
  assign idleHit   = (state == IDLE) && request && hit;
  assign missEntry = (state == IDLE) && request && !hit;
  assign lastWord  = mem_ack && (cnt == LINE_ADDR_LEN'(LINE_WORDS - 1));
  assign storeWe   = idleHit ? wr_req : 4'b0000;

  dcache_line_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .TAG_ADDR_LEN (TAG_ADDR_LEN)
  ) u_lineArray (
    .clk        (clk),
    .rst        (rst),
    .setIdx     (lookupSet),
    .wordIdx    (lookupWord),
    .tagOut     (lineTag),
    .validOut   (lineValid),
    .dirtyOut   (lineDirty),
    .wordOut    (lineWord),
    .byteWe     (storeWe),
    .wrData     (wr_data),
    .installEn  (state == INSTALL),
    .installTag (reqTag),
    .installLine(fillBuf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // NOTE: every combinational output gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (missEntry) nextState = (lineValid && lineDirty) ? SWAP_OUT : SWAP_IN;
      SWAP_OUT: if (lastWord) nextState = SWAP_IN;
      SWAP_IN:  if (lastWord) nextState = INSTALL;
      INSTALL:  nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
    miss      = request && !((state == IDLE) && hit);
    rd_data   = idleHit ? lineWord : '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      SWAP_OUT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lineTag, reqSet, cnt, 2'b00};
        mem_wdata = lineWord;
      end
      SWAP_IN: begin
        mem_req  = 1'b1;
        mem_addr = {reqTag, reqSet, cnt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      reqTag <= '0;
      reqSet <= '0;
    end else begin
      if (missEntry) begin
        reqTag <= addrTag;
        reqSet <= addrSet;
      end
      if (state == IDLE) cnt <= '0;
      else if ((state == SWAP_OUT || state == SWAP_IN) && mem_ack) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == SWAP_IN && mem_ack) fillBuf[cnt] <= mem_rdata;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (idleHit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (missEntry && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (missEntry && lineValid && lineDirty && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule
